// File: rtl/imem_ctrl.sv
// imem_ctrl: loads the instruction array, arbitrates core fetch vs debug
// reads, maps byte PC to word index and flags bad fetches.
// Ports: clk/reset_n; pc, instr, cpu_stall, fetch_fault (core);
// ld_* (program loader, valid/ready); dbg_* (debug read);
// mem_* (array side, combinational read, write on clk edge).
// Optional: define IMEM_LOAD_CHECKSUM_EN to add the ld_checksum output.
module imem_ctrl #(
  parameter int DEPTH = 256,
  parameter int BITS = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BITS-1:0]  pc,
  output logic [WIDTH-1:0] instr,
  output logic             cpu_stall,
  output logic             fetch_fault,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             ld_err,
  output logic [AW:0]      ld_count,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [WIDTH-1:0] ld_checksum,
`endif
  input  logic             dbg_req,
  input  logic [BITS-1:0]  dbg_addr,
  output logic             dbg_gnt,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_rvalid,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [BITS-1:0] DEPTH_B = BITS'(DEPTH);

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [AW:0] wptr;
  logic        prevgrant;

  logic is_idle;
  logic is_load;
  logic is_run;
  logic start;
  logic accept;
  logic overflow;
  logic finish;
  logic pc_fault;
  logic dbg_oor;

  assign is_idle = (state == S_IDLE);
  assign is_load = (state == S_LOAD);
  assign is_run  = (state == S_RUN);

  // A start pulse while already loading is ignored.
  assign start    = ld_start && !is_load;
  assign ld_ready = is_load && (wptr < DEPTH_W);
  assign accept   = ld_valid && ld_ready;
  // Valid word with the array full ends the load as an error.
  assign overflow = is_load && ld_valid && !ld_ready;
  assign finish   = (accept && ld_last) || overflow;

  // ld_start has priority; prevgrant reserves the next cycle for the core.
  assign dbg_gnt = is_run && dbg_req && !prevgrant && !ld_start;

  assign pc_fault = (pc[1:0] != 2'b00) || ((pc >> 2) >= DEPTH_B);
  assign dbg_oor  = (dbg_addr >> 2) >= DEPTH_B;

  assign fetch_fault = is_run && pc_fault;
  assign cpu_stall   = !is_run || dbg_gnt;
  assign instr = (is_run && !dbg_gnt && !pc_fault) ? mem_rdata : '0;

  assign mem_we    = accept;
  assign mem_wdata = ld_data;
  assign ld_count  = wptr;

  always_comb begin
    mem_addr = pc[AW+1:2];
    if (is_load) begin
      mem_addr = wptr[AW-1:0];
    end else if (dbg_gnt) begin
      mem_addr = dbg_addr[AW+1:2];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      is_idle: if (ld_start) state_nx = S_LOAD;
      is_load: if (finish) state_nx = S_RUN;
      is_run:  if (ld_start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wptr       <= '0;
      ld_err     <= 1'b0;
      ld_done    <= 1'b0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      prevgrant  <= 1'b0;
    end else begin
      state      <= state_nx;
      ld_done    <= finish;
      dbg_rvalid <= dbg_gnt;
      prevgrant  <= dbg_gnt;
      if (start) begin
        wptr   <= '0;
        ld_err <= 1'b0;
      end else if (accept) begin
        wptr <= wptr + 1'b1;
      end
      if (overflow) begin
        ld_err <= 1'b1;
      end
      if (dbg_gnt) begin
        dbg_rdata <= dbg_oor ? '0 : mem_rdata;
      end
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_checksum <= '0;
    end else if (start) begin
      ld_checksum <= '0;
    end else if (accept) begin
      ld_checksum <= ld_checksum + ld_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: randomized scoreboard bench for imem_ctrl with a
// behavioural array model and reference contents.
module tb_imem_ctrl;
  localparam int DEPTH = 256;
  localparam int BITS  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [BITS-1:0]  pc;
  logic [WIDTH-1:0] instr;
  logic             cpu_stall;
  logic             fetch_fault;
  logic             ld_start;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             ld_done;
  logic             ld_err;
  logic [AW:0]      ld_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] ld_checksum;
`endif
  logic             dbg_req;
  logic [BITS-1:0]  dbg_addr;
  logic             dbg_gnt;
  logic [WIDTH-1:0] dbg_rdata;
  logic             dbg_rvalid;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  imem_ctrl #(.DEPTH(DEPTH), .BITS(BITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .instr(instr),
    .cpu_stall(cpu_stall), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
    .ld_err(ld_err), .ld_count(ld_count),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .ld_checksum(ld_checksum),
`endif
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction array: combinational read, write on clock edge.
  logic [WIDTH-1:0] env_mem [DEPTH];
  always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = env_mem[mem_addr];

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          ref_cnt;
  bit          ref_err;
  logic [31:0] ref_sum;
  bit          prev_gnt;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  typedef struct { int cnt; bit err; logic [31:0] sum; } done_t;
  wr_t         wq[$];
  logic [31:0] rq[$];
  done_t       dq[$];
  logic [31:0] ldq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || ((p >> 2) >= DEPTH);
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output event.
  wr_t   m_w;
  done_t m_d;
  logic [31:0] m_r;
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {1'b1, mem_addr}, 0);
        end else begin
          m_w = wq.pop_front();
          chk("wr_addr", mem_addr, m_w.a);
          chk("wr_data", mem_wdata, m_w.d);
        end
      end
      if (dbg_rvalid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", dbg_rdata, 64'hdead);
        end else begin
          m_r = rq.pop_front();
          chk("dbg_rdata", dbg_rdata, m_r);
        end
      end
      if (ld_done) begin
        if (dq.size() == 0) begin
          chk("unexpected_ld_done", ld_count, 64'hdead);
        end else begin
          m_d = dq.pop_front();
          chk("done_count", ld_count, m_d.cnt);
          chk("done_err", ld_err, m_d.err);
`ifdef IMEM_LOAD_CHECKSUM_EN
          chk("done_checksum", ld_checksum, m_d.sum);
`endif
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic [31:0] p, input bit req,
                           input logic [31:0] a);
    bit g;
    logic [31:0] e;
    pc = p; dbg_req = req; dbg_addr = a;
    ld_start = 0; ld_valid = 0; ld_last = 0;
    g = req && !prev_gnt;
    if (g) rq.push_back(((a >> 2) < DEPTH) ? ref_mem[a >> 2] : 32'h0);
    if (g || pc_bad(p)) e = 0;
    else e = ref_mem[p >> 2];
    settle();
    chk("dbg_gnt", dbg_gnt, g);
    chk("cpu_stall", cpu_stall, g);
    chk("instr", instr, e);
    chk("fetch_fault", fetch_fault, pc_bad(p));
    chk("ld_ready_run", ld_ready, 0);
    prev_gnt = g;
    adv();
  endtask

  // Streams ldq; ends on accepted ld_last or on overflow.
  task automatic do_load(input bit last, input int gap_max);
    bit fin;
    int n;
    n = ldq.size();
    ld_start = 1; dbg_req = 1; dbg_addr = 0;
    settle();
    chk("start_no_gnt", dbg_gnt, 0);
    adv();
    ld_start = 0; dbg_req = 0;
    ref_cnt = 0; ref_err = 0; ref_sum = 0; prev_gnt = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        ld_valid = 0;
        settle();
        chk("ld_ready_gap", ld_ready, ref_cnt < DEPTH);
        chk("stall_load", cpu_stall, 1);
        adv();
      end
      ld_valid = 1; ld_data = ldq[i];
      ld_last = last && (i == n - 1);
      fin = 0;
      if (ref_cnt < DEPTH) begin
        wq.push_back('{AW'(ref_cnt), ldq[i]});
        ref_mem[ref_cnt] = ldq[i];
        ref_cnt++;
        ref_sum += ldq[i];
        fin = ld_last;
      end else begin
        ref_err = 1;
        fin = 1;
      end
      if (fin) dq.push_back('{ref_cnt, ref_err, ref_sum});
      settle();
      chk("ld_ready", ld_ready, !ref_err);
      chk("stall_load", cpu_stall, 1);
      chk("instr_load", instr, 0);
      chk("fault_load", fetch_fault, 0);
      adv();
      if (fin) break;
    end
    ld_valid = 0; ld_last = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0, 1: return 32'($urandom_range(0, DEPTH - 1)) << 2;
      2: return (32'($urandom_range(0, DEPTH - 1)) << 2) |
                32'($urandom_range(1, 3));
      default: return $urandom | 32'h400;
    endcase
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 0;
      ref_mem[i] = 0;
    end
    reset_n = 0; pc = 0; ld_start = 0; ld_valid = 0; ld_data = 0;
    ld_last = 0; dbg_req = 1; dbg_addr = 0; prev_gnt = 0;
    settle();
    chk("rst_ld_count", ld_count, 0);
    chk("rst_ld_err", ld_err, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_instr", instr, 0);
    adv();
    reset_n = 1;
    settle();
    chk("idle_gnt", dbg_gnt, 0);
    chk("idle_ready", ld_ready, 0);
    chk("idle_stall", cpu_stall, 1);
    adv();
    dbg_req = 0;

    // Directed first load.
    ldq = {32'h20080001, 32'h20080002, 32'h20080003, 32'h20080004};
    do_load(1, 0);
    settle();
    chk("count4", ld_count, 4);
    adv();
    run_cycle(32'h8, 0, 0);
    run_cycle(32'h6, 0, 0);
    run_cycle(32'h400, 0, 0);
    for (int i = 0; i < 4; i++) run_cycle(32'h0, 1, 32'h4);
    run_cycle(32'hc, 1, 32'h800);
    run_cycle(32'hc, 0, 0);
    run_cycle(32'h4, 0, 0);

    // Overflow: 257 words without ld_last.
    ldq.delete();
    for (int i = 0; i < DEPTH + 1; i++) ldq.push_back($urandom);
    do_load(0, 0);
    for (int i = 0; i < 10; i++) run_cycle(rand_pc(), 0, 0);
    settle();
    chk("ovf_err_sticky", ld_err, 1);
    chk("ovf_count", ld_count, DEPTH);
    adv();

    // Reset after two accepted words, then reload.
    ld_start = 1;
    settle();
    adv();
    ld_start = 0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = $urandom; ld_last = 0;
      wq.push_back('{AW'(i), ld_data});
      ref_mem[i] = ld_data;
      settle();
      adv();
    end
    ld_valid = 0;
    reset_n = 0;
    settle();
    chk("mid_rst_count", ld_count, 0);
    chk("mid_rst_ready", ld_ready, 0);
    chk("mid_rst_stall", cpu_stall, 1);
    chk("mid_rst_err", ld_err, 0);
    adv();
    reset_n = 1;
    adv();
    prev_gnt = 0;
    ldq = {32'h11111111, 32'h22222222, 32'h33333333};
    do_load(1, 1);
    run_cycle(32'h4, 0, 0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    ldq = {32'hffffffff, 32'h00000002};
    do_load(1, 0);
    settle();
    chk("checksum", ld_checksum, 32'h1);
    adv();
`endif

    // Randomized load / run rounds.
    for (int r = 0; r < 6; r++) begin
      ldq.delete();
      for (int i = 0; i < $urandom_range(1, 24); i++)
        ldq.push_back($urandom);
      do_load(1, 2);
      for (int i = 0; i < 40; i++) begin
        run_cycle(rand_pc(), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 3) == 0) ? $urandom : rand_pc());
      end
    end
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
